// File: rtl/div_iter_unit.sv
// ============================================================================
// Module   : div_iter_unit
// Brief    : Multi-cycle radix-2 restoring 32-bit divider for the execute
//            stage. Drives the divide stall and presents HI/LO results.
//            Optional macro DIV_ZERO_FAST_EN: divide-by-zero skips iteration.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_iter_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             pipe_stall,
    input  logic             flush,
    output logic             div_stall,
    output logic             result_valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0]       c_IDLE     = 2'd0;
    localparam logic [1:0]       c_BUSY     = 2'd1;
    localparam logic [1:0]       c_DONE     = 2'd2;
    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_nextState;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_divisor;
    logic             r_quoNeg;
    logic             r_remNeg;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_load;
    logic             w_step;
    logic             w_divStall;
    logic             w_resultValid;

    logic             w_aNegIn;
    logic             w_bNegIn;
    logic             w_quoNegIn;
    logic [WIDTH-1:0] w_absA;
    logic [WIDTH-1:0] w_absB;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_remNext;
    logic [WIDTH-1:0] w_quoNext;

`ifdef DIV_ZERO_FAST_EN
    localparam logic [WIDTH-1:0] c_ONES = '1;
    logic w_bZero;
    assign w_bZero = (b == '0);
`endif

    // Operand magnitudes and result signs, captured once at issue
    assign w_aNegIn   = signed_div & a[WIDTH-1];
    assign w_bNegIn   = signed_div & b[WIDTH-1];
    assign w_quoNegIn = (a[WIDTH-1] ^ b[WIDTH-1]) & signed_div;
    assign w_absA     = w_aNegIn ? -a : a;
    assign w_absB     = w_bNegIn ? -b : b;

    // Restoring step: the dividend shifts out of r_quo as quotient bits shift in
    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_diff    = w_shift - {1'b0, r_divisor};
    assign w_remNext = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_quoNext = {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState   = r_state;
        w_divStall    = 1'b0;
        w_resultValid = 1'b0;
        w_load        = 1'b0;
        w_step        = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_divStall = 1'b1;
                    w_load     = 1'b1;
`ifdef DIV_ZERO_FAST_EN
                    w_nextState = w_bZero ? c_DONE : c_BUSY;
`else
                    w_nextState = c_BUSY;
`endif
                end
            end
            c_BUSY: begin
                w_divStall = 1'b1;
                w_step     = 1'b1;
                if (r_cnt == c_LAST_CNT) begin
                    w_nextState = c_DONE;
                end
            end
            c_DONE: begin
                w_resultValid = 1'b1;
                if (!pipe_stall) begin
                    w_nextState = c_IDLE;
                end
            end
            default: begin
                w_nextState = c_IDLE;
            end
        endcase
        // Flush must never be held off by the divider, and an annulled
        // divide must not touch HI/LO.
        if (flush) begin
            w_nextState   = c_IDLE;
            w_divStall    = 1'b0;
            w_resultValid = 1'b0;
            w_load        = 1'b0;
            w_step        = 1'b0;
        end
        if (!resetn) begin
            w_divStall    = 1'b0;
            w_resultValid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_quoNeg  <= 1'b0;
            r_remNeg  <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else if (w_load) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= w_absA;
            r_divisor <= w_absB;
            r_quoNeg  <= w_quoNegIn;
            r_remNeg  <= w_aNegIn;
`ifdef DIV_ZERO_FAST_EN
            if (w_bZero) begin
                r_lo <= w_quoNegIn ? -c_ONES : c_ONES;
                r_hi <= a;
            end
`endif
        end else if (w_step) begin
            r_cnt <= r_cnt + c_CNT_ONE;
            r_rem <= w_remNext;
            r_quo <= w_quoNext;
            if (r_cnt == c_LAST_CNT) begin
                r_lo <= r_quoNeg ? -w_quoNext : w_quoNext;
                r_hi <= r_remNeg ? -w_remNext : w_remNext;
            end
        end
    end

    assign div_stall    = w_divStall;
    assign result_valid = w_resultValid;
    assign hi           = r_hi;
    assign lo           = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_div_iter_unit.sv
// ============================================================================
// Module   : tb_div_iter_unit
// Brief    : Directed self-checking bench for div_iter_unit with a result
//            scoreboard. Honours DIV_ZERO_FAST_EN for the divide-by-zero stall.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_iter_unit;

    logic        clk;
    logic        resetn;
    logic        start;
    logic        signed_div;
    logic [31:0] a;
    logic [31:0] b;
    logic        pipe_stall;
    logic        flush;
    logic        div_stall;
    logic        result_valid;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

`ifdef DIV_ZERO_FAST_EN
    localparam int c_ZERO_STALL = 1;
`else
    localparam int c_ZERO_STALL = 33;
`endif

    div_iter_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .signed_div  (signed_div),
        .a           (a),
        .b           (b),
        .pipe_stall  (pipe_stall),
        .flush       (flush),
        .div_stall   (div_stall),
        .result_valid(result_valid),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: magnitude divide then sign fix; b==0 yields all-ones/|a|
    function automatic exp_t model(input logic [31:0] ra, input logic [31:0] rb, input logic s);
        exp_t        e;
        logic [31:0] ua, ub, q, r;
        ua = (s && ra[31]) ? -ra : ra;
        ub = (s && rb[31]) ? -rb : rb;
        if (ub == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = ua;
        end else begin
            q = ua / ub;
            r = ua % ub;
        end
        e.lo = (s && (ra[31] ^ rb[31])) ? -q : q;
        e.hi = (s && ra[31]) ? -r : r;
        return e;
    endfunction

    task automatic push(input logic [31:0] eh, input logic [31:0] el);
        exp_t e;
        e.hi = eh;
        e.lo = el;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic s);
        @(negedge clk);
        a          = ia;
        b          = ib;
        signed_div = s;
        start      = 1'b1;
        #1;
    endtask

    // Entered in the issue cycle; leaves in the DONE cycle
    task automatic wait_result(input int expStall, input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (div_stall === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        check({tag, "_stall_cycles"}, n, expStall);
        check({tag, "_valid"}, {31'd0, result_valid}, 32'd1);
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_lo"}, lo, e.lo);
            check({tag, "_hi"}, hi, e.hi);
        end
    endtask

    task automatic finish_div(input string tag);
        start = 1'b0;
        @(negedge clk);
        #1;
        check({tag, "_valid_drop"}, {31'd0, result_valid}, 32'd0);
        check({tag, "_stall_idle"}, {31'd0, div_stall}, 32'd0);
    endtask

    initial begin
        exp_t        e;
        logic [31:0] hold_hi;
        logic [31:0] hold_lo;

        resetn     = 1'b0;
        start      = 1'b1;
        signed_div = 1'b0;
        a          = 32'd0;
        b          = 32'd0;
        pipe_stall = 1'b0;
        flush      = 1'b0;

        // Reset state, outputs low even with start high
        @(negedge clk);
        #1;
        check("rst_stall", {31'd0, div_stall}, 32'd0);
        check("rst_valid", {31'd0, result_valid}, 32'd0);
        @(negedge clk);
        #1;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        start  = 1'b0;
        resetn = 1'b1;
        @(negedge clk);

        // DIVU 100/7
        issue(32'd100, 32'd7, 1'b0);
        push(32'd2, 32'd14);
        wait_result(33, "divu_100_7");
        finish_div("divu_100_7");

        // DIV -7/2
        issue(32'hFFFF_FFF9, 32'd2, 1'b1);
        push(32'hFFFF_FFFF, 32'hFFFF_FFFD);
        wait_result(33, "div_m7_2");
        finish_div("div_m7_2");

        // Signed overflow
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        push(32'd0, 32'h8000_0000);
        wait_result(33, "div_ovf");
        finish_div("div_ovf");

        // Result held under pipe_stall, start still high
        issue(32'd1000, 32'd33, 1'b0);
        push(32'd10, 32'd30);
        wait_result(33, "hold");
        pipe_stall = 1'b1;
        hold_hi    = hi;
        hold_lo    = lo;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("hold_valid", {31'd0, result_valid}, 32'd1);
            check("hold_stall", {31'd0, div_stall}, 32'd0);
            check("hold_hi", hi, 32'd10);
            check("hold_lo", lo, 32'd30);
        end
        pipe_stall = 1'b0;
        finish_div("hold");
        check("idle_keep_hi", hi, hold_hi);
        check("idle_keep_lo", lo, hold_lo);

        // Flush at BUSY cycle 10
        issue(32'd50, 32'd5, 1'b0);
        repeat (10) @(negedge clk);
        #1;
        flush = 1'b1;
        start = 1'b0;
        #1;
        check("flush_stall_now", {31'd0, div_stall}, 32'd0);
        check("flush_valid_now", {31'd0, result_valid}, 32'd0);
        @(negedge clk);
        #1;
        flush = 1'b0;
        for (int i = 0; i < 40; i++) begin
            check("flush_no_valid", {31'd0, result_valid}, 32'd0);
            check("flush_no_stall", {31'd0, div_stall}, 32'd0);
            @(negedge clk);
            #1;
        end
        issue(32'd9, 32'd3, 1'b0);
        push(32'd0, 32'd3);
        wait_result(33, "after_flush");
        finish_div("after_flush");

        // Reset mid-BUSY
        issue(32'd123, 32'd4, 1'b0);
        repeat (5) @(negedge clk);
        #1;
        resetn = 1'b0;
        start  = 1'b0;
        @(negedge clk);
        #1;
        check("midrst_stall", {31'd0, div_stall}, 32'd0);
        check("midrst_valid", {31'd0, result_valid}, 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        resetn = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            check("postrst_stall", {31'd0, div_stall}, 32'd0);
            check("postrst_valid", {31'd0, result_valid}, 32'd0);
        end

        // Divide by zero
        issue(32'd5, 32'd0, 1'b0);
        push(32'd5, 32'hFFFF_FFFF);
        wait_result(c_ZERO_STALL, "divu_zero");
        finish_div("divu_zero");

        issue(32'hFFFF_FFF6, 32'd0, 1'b1);
        e = model(32'hFFFF_FFF6, 32'd0, 1'b1);
        sb.push_back(e);
        wait_result(c_ZERO_STALL, "div_zero_neg");
        finish_div("div_zero_neg");

        // Back-to-back with start held
        issue(32'd200, 32'd9, 1'b0);
        push(32'd2, 32'd22);
        wait_result(33, "b2b_first");
        a = 32'd77;
        b = 32'd8;
        push(32'd5, 32'd9);
        @(negedge clk);
        #1;
        check("b2b_gap_valid", {31'd0, result_valid}, 32'd0);
        check("b2b_second_stall", {31'd0, div_stall}, 32'd1);
        wait_result(33, "b2b_second");
        finish_div("b2b_second");

        // Mixed random operands
        for (int i = 0; i < 4; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = $urandom_range(1, 100000);
            if (i[1]) rb = -rb;
            issue(ra, rb, i[0]);
            e = model(ra, rb, i[0]);
            sb.push_back(e);
            wait_result(33, "rand");
            finish_div("rand");
        end

        check("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/div_iter_unit.md
Name: div_iter_unit

Overview:
- Multi-cycle radix-2 32-bit divider in the execute stage.
- It is the producer of the execute-stage divide stall consumed by the hazard unit.
- Asserts div_stall while an issued DIV/DIVU is in progress, then presents quotient/remainder for HI/LO write.
- Honours pipeline hold (other stall sources) and exception flush so an annulled divide never writes HI/LO.

Parameters:
- WIDTH, 32, operand/result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  synchronous reset, active-low; sampled only on the rising edge of clk.
- start  input  1  DIV/DIVU instruction valid in E stage; held high by the pipeline while E is stalled.
- signed_div  input  1  1 = DIV (signed), 0 = DIVU; sampled with start in IDLE.
- a  input  WIDTH  dividend (rs).
- b  input  WIDTH  divisor (rt).
- pipe_stall  input  1  OR of all non-divider stalls (i_stall | d_stall | mul_stall); E cannot advance.
- flush  input  1  exception/eret flush of E and younger stages.
- div_stall  output  1  to hazard unit; holds F/D/E/M/W.
- result_valid  output  1  hi/lo valid; HI/LO write enable qualifier.
- hi  output  WIDTH  remainder.
- lo  output  WIDTH  quotient.

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset (resetn=0 at a clk edge): state=IDLE, counter=0, hi=0, lo=0. div_stall=0 and result_valid=0 in the same cycle, independent of other inputs. Reset mid-BUSY abandons the operation.
- IDLE:
  - div_stall = start & ~flush (combinational).
  - On a clk edge with start & ~flush, latch |a|, |b|, the quotient sign (a[31]^b[31])&signed_div, and the remainder sign a[31]&signed_div; counter=0; go to BUSY.
  - Operands are captured once; later changes to a/b are ignored.
- BUSY:
  - One restoring shift-subtract step per cycle; counter increments.
  - After WIDTH steps (counter==WIDTH-1 on the edge), go to DONE.
  - div_stall=1 during BUSY.
  - Latency: start seen in IDLE at cycle 0, BUSY cycles 1..32, DONE at cycle 33. div_stall is high for cycles 0..32 (33 cycles).
- DONE:
  - div_stall=0, result_valid=1.
  - hi/lo hold sign-corrected results: lo negated if the quotient sign is set, hi negated if the remainder sign is set.
  - Stay in DONE while pipe_stall=1, so the result is held and no restart occurs.
  - Go to IDLE on an edge with pipe_stall=0; the instruction leaves E on that edge.
  - hi/lo keep their last value in IDLE, but result_valid=0.
- Flush:
  - flush=1 in any state forces IDLE on the next edge.
  - div_stall and result_valid are gated by ~flush combinationally, so a flush is never blocked by the divider.
- Divide by zero (b==0): no trap. Run the full iteration; result lo=all ones before sign fix, hi=|a| before sign fix. The bench checks the exact values the algorithm produces.
- Signed overflow 0x80000000 / 0xFFFFFFFF (DIV): lo=0x80000000, hi=0.
- All arithmetic is on WIDTH+1-bit partial remainder; no X propagation from unused bits.

Optional Feature:
- Macro DIV_ZERO_FAST_EN.
- Defined: in IDLE with start and b==0, skip BUSY. Go directly to DONE with lo=0xFFFFFFFF (unsigned) or the same pattern after sign fix, and hi=a. div_stall is high for exactly 1 cycle.
- Not defined: divide-by-zero takes the full 33-cycle stall like any other divide.

Test Plan:
- DIVU a=100, b=7, no other stalls -> div_stall high 33 cycles; lo=14, hi=2, result_valid high 1 cycle; state returns to IDLE.
- DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Result with pipe_stall=1 for 5 cycles after DONE -> result_valid stays 1 and hi/lo stable for 6 cycles; div_stall=0; no second division starts while start remains high.
- flush asserted at BUSY cycle 10 -> div_stall drops the same cycle, IDLE next edge; result_valid never asserts; a new DIVU 9/3 then gives lo=3, hi=0.
- resetn=0 during BUSY -> next cycle div_stall=0, result_valid=0, hi=lo=0. b=0 DIVU a=5 -> lo=0xFFFFFFFF, hi=5. With DIV_ZERO_FAST_EN, stall is 1 cycle; without it, 33 cycles.
- Back-to-back divides (start held, new operands after DONE->IDLE) -> second result correct. The second divide's stall begins the cycle after the first's DONE exits, with no lost or duplicated result_valid.
